// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
// Address width, length width and loader state encoding.
package instr_mem_loader_pkg;

  localparam int INSTR_MEM_ADDR_WIDTH = 4;
  localparam int LEN_WIDTH = INSTR_MEM_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_LOAD_HI = 3'd1,
    S_LOAD_LO = 3'd2,
    S_FLUSH   = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  // A requested length of zero means a full memory image.
  function automatic logic [LEN_WIDTH-1:0] norm_len(
    input logic [LEN_WIDTH-1:0] l
  );
    logic [LEN_WIDTH-1:0] full;
    full = '0;
    full[INSTR_MEM_ADDR_WIDTH] = 1'b1;
    return (l == '0) ? full : l;
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_pack16.sv
// High-byte holding register and big-endian word assembly.
// The word is formed from the held byte and the live low byte.
module instr_mem_loader_byte_pack16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic [7:0]  byte_data,
  output logic [15:0] word
);

  logic [7:0] hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
    end else if (capture) begin
      hi <= byte_data;
    end
  end

  assign word = {hi, byte_data};

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader for the mips_16 instruction memory.
// Packs host bytes into words, writes them and gates the core stall.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_start,
  input  logic [LEN_WIDTH-1:0]            load_len,
  input  logic                            byte_valid,
  input  logic [7:0]                      byte_data,
  output logic                            byte_ready,
  output logic                            mem_we,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] mem_waddr,
  output logic [15:0]                     mem_wdata,
  output logic                            core_stall,
  output logic                            load_done,
  output logic                            load_busy
);

  state_t state;
  state_t state_n;

  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic                 restart;
  logic                 hi_we;
  logic                 word_we;
  logic [15:0]          word;

  instr_mem_loader_byte_pack16 u_pack (
    .clk       (clk),
    .rst       (rst),
    .capture   (hi_we),
    .byte_data (byte_data),
    .word      (word)
  );

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_n = state;
    restart = 1'b0;
    hi_we   = 1'b0;
    word_we = 1'b0;
    unique case (state)
      S_HOLD, S_RUN: begin
        if (load_start) begin
          state_n = S_LOAD_HI;
          restart = 1'b1;
        end
      end
      S_LOAD_HI: begin
        if (load_start) begin
          state_n = S_LOAD_HI;
          restart = 1'b1;
        end else if (byte_valid) begin
          state_n = S_LOAD_LO;
          hi_we   = 1'b1;
        end
      end
      S_LOAD_LO: begin
        // An abort wins over a low byte arriving in the same cycle.
        if (load_start) begin
          state_n = S_LOAD_HI;
          restart = 1'b1;
        end else if (byte_valid) begin
          word_we = 1'b1;
          if (cnt_inc == len) begin
            state_n = S_FLUSH;
          end else begin
            state_n = S_LOAD_HI;
          end
        end
      end
      S_FLUSH: begin
        state_n = S_RUN;
      end
      default: begin
        state_n = S_HOLD;
      end
    endcase
  end

  assign byte_ready = (state == S_LOAD_HI) ||
                      (state == S_LOAD_LO);
  assign load_busy  = byte_ready || (state == S_FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_HOLD;
      len        <= '0;
      cnt        <= '0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      load_done  <= 1'b0;
      core_stall <= 1'b1;
    end else begin
      state      <= state_n;
      mem_we     <= word_we;
      load_done  <= (state == S_FLUSH);
      core_stall <= (state_n != S_RUN);
      if (restart) begin
        len <= norm_len(load_len);
        cnt <= '0;
      end else if (word_we) begin
        cnt       <= cnt_inc;
        mem_waddr <= cnt[INSTR_MEM_ADDR_WIDTH-1:0];
        mem_wdata <= word;
      end
    end
  end

endmodule
